// File: rtl/counter_pkg.sv
// Shared definitions for the counters library: count-mode and direction encodings.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Reserved mode encoding behaves as WRAP.
    function automatic logic [1:0] effective_mode(input logic [1:0] mode);
        return (mode == MODE_RSVD) ? MODE_WRAP : mode;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_term_detect.sv
// Terminal-value detection for mode_counter.
//   q_i         current count
//   limit_i     upper bound of the range [0, limit]
//   dir_i       0 = up, 1 = down
//   at_term_o   current count is terminal (combinational)
//   next_term_o the value one count step away is terminal (combinational)
module counter_term_detect
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             dir_i,
    output logic             at_term_o,
    output logic             next_term_o
);

    localparam int unsigned EXT_W = WIDTH + 1;

    logic [EXT_W-1:0] q_plus_one;

    // Extended by one bit so q+1 never wraps before the compare.
    assign q_plus_one = EXT_W'(q_i) + EXT_W'(1);

    always_comb begin
        at_term_o   = 1'b0;
        next_term_o = 1'b0;
        if (dir_i == DIR_UP) begin
            // >= so a limit lowered below the count is still terminal.
            at_term_o   = (q_i >= limit_i);
            next_term_o = (q_plus_one >= EXT_W'(limit_i));
        end else begin
            at_term_o   = (q_i == '0);
            next_term_o = (q_i == WIDTH'(1));
        end
    end

endmodule : counter_term_detect

// File: rtl/mode_counter.sv
// Up/down counter over [0, limit] with load and WRAP / SATURATE / ONESHOT
// end-of-range behaviour, a registered terminal-count pulse and a
// combinational cascade carry.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   en          count enable, one step per cycle
//   dir         0 = up, 1 = down
//   mode        0 WRAP, 1 SATURATE, 2 ONESHOT, 3 behaves as WRAP
//   limit       upper bound of the range
//   load        synchronous load strobe, load_val -> Q
//   Q           registered count
//   tc          registered one-cycle pulse when a step lands on terminal
//   done        registered ONESHOT-finished flag
//   carry       combinational, en && at_term && !done && effective WRAP
module mode_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             done,
    output logic             carry
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             at_term;
    logic             next_term;
    logic [1:0]       mode_eff;

    counter_term_detect #(
        .WIDTH (WIDTH)
    ) u_term (
        .q_i         (q_q),
        .limit_i     (limit),
        .dir_i       (dir),
        .at_term_o   (at_term),
        .next_term_o (next_term)
    );

    assign mode_eff = effective_mode(mode);

    // Next-state: load beats a count step; done freezes counting.
    always_comb begin
        q_d    = q_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (load) begin
            q_d    = load_val;
            done_d = 1'b0;
        end else if (en && !done_q) begin
            if (!at_term) begin
                q_d  = (dir == DIR_DOWN) ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
                tc_d = next_term;
                if (mode_eff == MODE_ONESHOT && next_term) begin
                    done_d = 1'b1;
                end
            end else begin
                // Steps out of terminal never pulse tc.
                case (mode_eff)
                    MODE_WRAP:    q_d = (dir == DIR_DOWN) ? limit : '0;
                    MODE_ONESHOT: done_d = 1'b1;
                    default:      q_d = q_q;
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign Q     = q_q;
    assign tc    = tc_q;
    assign done  = done_q;
    assign carry = en && at_term && !done_q && (mode_eff == MODE_WRAP);

endmodule : mode_counter

// File: tb/tb_mode_counter.sv
module tb_mode_counter;
    import counter_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset, en, dir, load;
    logic [1:0]   mode;
    logic [W-1:0] limit, load_val;
    logic [W-1:0] q;
    logic         tc, done, carry;

    logic         casc_en;
    logic [W-1:0] lo_q, hi_q;
    logic         lo_tc, hi_tc, lo_done, hi_done, lo_carry, hi_carry;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int hi_tc_cnt = 0;
    int lo_tc_cnt = 0;

    // Reference model state
    int m_q;
    bit m_tc, m_done;

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .limit(limit), .load(load), .load_val(load_val),
        .Q(q), .tc(tc), .done(done), .carry(carry)
    );

    mode_counter #(.WIDTH(W)) u_lo (
        .clk(clk), .reset(reset), .en(casc_en), .dir(DIR_UP), .mode(MODE_WRAP),
        .limit(4'd15), .load(1'b0), .load_val(4'd0),
        .Q(lo_q), .tc(lo_tc), .done(lo_done), .carry(lo_carry)
    );

    mode_counter #(.WIDTH(W)) u_hi (
        .clk(clk), .reset(reset), .en(lo_carry), .dir(DIR_UP), .mode(MODE_WRAP),
        .limit(4'd15), .load(1'b0), .load_val(4'd0),
        .Q(hi_q), .tc(hi_tc), .done(hi_done), .carry(hi_carry)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_term(input int qv);
        return dir ? (qv == 0) : (qv >= int'(limit));
    endfunction

    function automatic bit model_is_wrap();
        return (mode == 2'd0) || (mode == 2'd3);
    endfunction

    // Spec-level model, advanced on each rising edge with the sampled inputs.
    always @(posedge clk) begin
        int lim;
        int nq;
        lim = int'(limit);
        if (reset) begin
            m_q = 0; m_tc = 0; m_done = 0;
        end else if (load) begin
            m_q = int'(load_val); m_tc = 0; m_done = 0;
        end else if (en && !m_done) begin
            m_tc = 0;
            if (!model_term(m_q)) begin
                nq = dir ? m_q - 1 : m_q + 1;
                m_q = nq;
                m_tc = model_term(nq);
                if (mode == 2'd2 && m_tc) m_done = 1;
            end else if (model_is_wrap()) begin
                m_q = dir ? lim : 0;
            end else if (mode == 2'd2) begin
                m_done = 1;
            end
        end else begin
            m_tc = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("Q", 32'(q), 32'(m_q));
            chk("tc", 32'(tc), 32'(m_tc));
            chk("done", 32'(done), 32'(m_done));
            chk("carry", 32'(carry),
                32'(en && model_term(m_q) && !m_done && model_is_wrap()));
            if (hi_tc) hi_tc_cnt++;
            if (lo_tc) lo_tc_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq1[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    int seq2[6] = '{3, 2, 1, 0, 0, 0};

    initial begin
        reset = 1'b1; en = 1'b0; dir = DIR_UP; load = 1'b0; mode = MODE_WRAP;
        limit = 4'd5; load_val = 4'd0; casc_en = 1'b0;
        repeat (2) tick();
        chk("reset_Q", 32'(q), 32'd0);
        chk("reset_tc", 32'(tc), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk_en = 1'b1;

        // Up WRAP, limit 5
        reset = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("wrap_up_Q", 32'(q), 32'(seq1[i]));
            chk("wrap_up_tc", 32'(tc), 32'(seq1[i] == 5 && i == 5));
            chk("wrap_up_carry", 32'(carry), 32'(seq1[i] == 5));
            tick();
        end

        // Down SATURATE from load 3
        en = 1'b0; dir = DIR_DOWN; mode = MODE_SAT; load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("sat_down_Q", 32'(q), 32'(seq2[i]));
            chk("sat_down_tc", 32'(tc), 32'(i == 3));
            chk("sat_down_done", 32'(done), 32'd0);
            tick();
        end

        // ONESHOT up, limit 3
        en = 1'b0; dir = DIR_UP; mode = MODE_ONESHOT; limit = 4'd3;
        load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0; en = 1'b1;
        repeat (3) tick();
        chk("oneshot_Q3", 32'(q), 32'd3);
        chk("oneshot_tc", 32'(tc), 32'd1);
        chk("oneshot_done", 32'(done), 32'd1);
        repeat (3) tick();
        chk("oneshot_hold_Q", 32'(q), 32'd3);
        chk("oneshot_hold_done", 32'(done), 32'd1);
        chk("oneshot_hold_tc", 32'(tc), 32'd0);
        load = 1'b1; load_val = 4'd1;
        tick();
        load = 1'b0;
        chk("oneshot_reload_Q", 32'(q), 32'd1);
        chk("oneshot_reload_done", 32'(done), 32'd0);
        tick();
        chk("oneshot_resume_Q", 32'(q), 32'd2);
        tick();
        chk("oneshot_resume_Q3", 32'(q), 32'd3);
        chk("oneshot_resume_done", 32'(done), 32'd1);

        // WRAP up, limit lowered below Q
        mode = MODE_WRAP; limit = 4'd6; en = 1'b0; load = 1'b1; load_val = 4'd4;
        tick();
        load = 1'b0; limit = 4'd2; en = 1'b1;
        tick();
        chk("limit_lowered_Q", 32'(q), 32'd0);

        // Down from 9 above limit 2, then wrap to limit
        en = 1'b0; dir = DIR_DOWN; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; en = 1'b1;
        chk("down_above_Q9", 32'(q), 32'd9);
        repeat (9) tick();
        chk("down_above_Q0", 32'(q), 32'd0);
        chk("down_above_tc", 32'(tc), 32'd1);
        tick();
        chk("down_wrap_Q", 32'(q), 32'd2);
        chk("down_wrap_tc", 32'(tc), 32'd0);

        // Reset beats load and en at Q=7
        en = 1'b0; load = 1'b1; load_val = 4'd7;
        tick();
        chk("load7_Q", 32'(q), 32'd7);
        reset = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd3;
        tick();
        chk("rst_pri_Q", 32'(q), 32'd0);
        chk("rst_pri_tc", 32'(tc), 32'd0);
        chk("rst_pri_done", 32'(done), 32'd0);
        reset = 1'b0; load = 1'b1; en = 1'b1; load_val = 4'd6;
        tick();
        chk("load_pri_Q", 32'(q), 32'd6);

        // limit 0 up: stuck at terminal, no repeated tc
        load = 1'b0; dir = DIR_UP; limit = 4'd0;
        repeat (3) tick();
        chk("lim0_Q", 32'(q), 32'd0);
        chk("lim0_tc", 32'(tc), 32'd0);

        // Reserved mode behaves as WRAP
        mode = MODE_RSVD; limit = 4'd2;
        tick();
        tick();
        chk("rsvd_Q2", 32'(q), 32'd2);
        chk("rsvd_tc", 32'(tc), 32'd1);
        chk("rsvd_carry", 32'(carry), 32'd1);
        tick();
        chk("rsvd_wrap_Q", 32'(q), 32'd0);
        en = 1'b0;

        // Cascade of two stages, 256 enables
        casc_en = 1'b1;
        repeat (256) tick();
        casc_en = 1'b0;
        tick();
        chk("casc_lo_Q", 32'(lo_q), 32'd0);
        chk("casc_hi_Q", 32'(hi_q), 32'd0);
        chk("casc_hi_tc_count", 32'(hi_tc_cnt), 32'd1);
        chk("casc_lo_tc_count", 32'(lo_tc_cnt), 32'd16);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mode_counter
